mem_access_adapter: RTL
=======================

// Module: mem_access_adapter
// PURPOSE
//   Upstream front-end of the Cache. Converts CPU load/store requests (byte, half, word;
//   signed/unsigned) into aligned 32-bit cache accesses with byte write masks.
//   Sequences the cache handshake (busy / data_out_ready) and returns the response:
//   lane-extracted, sign/zero-extended read data, or an error for misaligned requests.
// PARAMETERS
//   ADDRESS_BITWIDTH  32  width of byte addresses on the request side and to the cache
// PORTS
//   clk             in   1   system clock; single clock domain
//   rst_n           in   1   asynchronous active-low reset
//   req_valid       in   1   request present; sampled only while req_ready=1
//   req_ready       out  1   adapter idle, accepts request this cycle
//   req_write       in   1   1: store, 0: load
//   req_size        in   2   0: byte, 1: half, 2: word, 3: reserved (treated as misaligned)
//   req_unsigned    in   1   loads only: 1 zero-extend, 0 sign-extend
//   req_addr        in   AW  byte address
//   req_wdata       in   32  store data, right-aligned (bits [7:0] / [15:0] / [31:0])
//   rsp_valid       out  1   one-cycle response pulse
//   rsp_error       out  1   qualifies rsp_valid: misaligned or reserved size
//   rsp_rdata       out  32  load result; 0 for stores and errors
//   enable          out  1   to Cache.enable
//   address         out  AW  to Cache.address, always {addr[AW-1:2],2'b00}
//   data_in         out  32  to Cache.data_in, store data shifted into lanes
//   write_enable    out  4   to Cache.write_enable, byte mask
//   data_out        in   32  from Cache.data_out
//   data_out_ready  in   1   from Cache.data_out_ready
//   busy            in   1   from Cache.busy
// BEHAVIOUR
//   Reset: state=IDLE; req_ready=1 after reset release. All other outputs 0. Internal
//     latches are cleared. Reset mid-operation aborts to IDLE with no response. Any cache
//     transaction in flight is left to the cache's own reset.
//   States: IDLE, READ, WRITE, RESP. A registered 'issued' flag is cleared on entry to
//     READ/WRITE and set after the first cycle in that state.
//   IDLE: req_ready=1. On req_valid, latch addr, size, unsigned, write and wdata.
//     Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size=3.
//       Misaligned -> RESP with rsp_error=1 and rsp_rdata=0. Never touches the cache.
//     Aligned store -> WRITE. Aligned load -> READ.
//   Masks: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//     data_in = wdata << (8*addr[1:0]). Lanes outside the mask are 0.
//   WRITE: enable=1, write_enable=mask, data_in and address held stable.
//     Exit to RESP in the first cycle with issued=1 and busy=0. Minimum 2 cycles in WRITE.
//   READ: enable=1, write_enable=0.
//     Exit to RESP in the first cycle with issued=1 and data_out_ready=1.
//     On that cycle register rdata: data_out >> (8*addr[1:0]), masked to size, then
//     sign-extended (req_unsigned=0) or zero-extended.
//   RESP: rsp_valid=1 for exactly one cycle, enable=0, write_enable=0; then IDLE.
//     rsp_rdata and rsp_error hold their values until the next RESP or reset.
//   Latency, hit, accept edge to rsp_valid: load 3 cycles, store 3 cycles, error 1 cycle.
//     Misses add the cache stall time. The adapter has no timeout.
//   No back-to-back overlap: req_ready=0 in READ/WRITE/RESP. A new request is accepted
//     on the cycle after RESP at the earliest.
//   req_* inputs are ignored outside IDLE; changing them mid-operation has no effect.
// TESTING
//   sw 0x8765_4321 @0x10 -> write_enable=4'b1111, address=0x10; rsp_valid=1, rsp_error=0
//   lb @0x13 -> 0xFFFF_FF87; lbu @0x13 -> 0x0000_0087; lh @0x12 -> 0xFFFF_8765
//   sb 0xAA @0x11 -> write_enable=4'b0010, data_in=0x0000_AA00; then lw @0x10 -> 0x8765_AA21
//   lw @0x12 and lh @0x05 -> rsp_error=1, rsp_rdata=0, enable never asserted, 1-cycle latency
//   lw to an uncached line (cache miss) -> enable held through busy; data correct after refill
//   rst_n=0 in READ -> all outputs 0 asynchronously; no rsp_valid; after release req_ready=1

Source files
------------

// File: rtl/mem_access_adapter.sv
// Purpose: turns CPU byte/half/word loads and stores into aligned 32-bit cache accesses with byte masks.
// Latency: a hit returns 3 cycles after the accept cycle, a misaligned request 1 cycle after; misses add the cache stall time.
// Backpressure: one request in flight; req_ready is low from the accept until the response cycle has passed.
module mem_access_adapter #(
    parameter int ADDRESS_BITWIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [ADDRESS_BITWIDTH-1:0] req_addr,
    input  logic [31:0]                 req_wdata,
    output logic                        rsp_valid,
    output logic                        rsp_error,
    output logic [31:0]                 rsp_rdata,
    output logic                        enable,
    output logic [ADDRESS_BITWIDTH-1:0] address,
    output logic [31:0]                 data_in,
    output logic [3:0]                  write_enable,
    input  logic [31:0]                 data_out,
    input  logic                        data_out_ready,
    input  logic                        busy
);
    localparam int AW = ADDRESS_BITWIDTH;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          issued;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          error_q;

    logic          req_misaligned;
    logic [3:0]    lane_mask;
    logic [31:0]   wdata_sized;
    logic [31:0]   rd_shifted;
    logic [31:0]   rdata_ext;

    always_comb begin
        req_misaligned = (req_size == 2'd3)
                      || ((req_size == 2'd1) && req_addr[0])
                      || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    end

    // Upper store-data bits beyond the access size are don't-care upstream, so drop them before shifting.
    always_comb begin
        lane_mask   = 4'b1111;
        wdata_sized = wdata_q;
        case (size_q)
            2'd0: begin
                lane_mask   = 4'b0001 << addr_q[1:0];
                wdata_sized = {24'd0, wdata_q[7:0]};
            end
            2'd1: begin
                lane_mask   = 4'b0011 << {addr_q[1], 1'b0};
                wdata_sized = {16'd0, wdata_q[15:0]};
            end
            default: begin
                lane_mask   = 4'b1111;
                wdata_sized = wdata_q;
            end
        endcase
    end

    always_comb begin
        rd_shifted = data_out >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'd0:    rdata_ext = {{24{~uns_q & rd_shifted[7]}}, rd_shifted[7:0]};
            2'd1:    rdata_ext = {{16{~uns_q & rd_shifted[15]}}, rd_shifted[15:0]};
            default: rdata_ext = rd_shifted;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_misaligned) state_nxt = RESP;
                    else if (req_write) state_nxt = WRITE;
                    else                state_nxt = READ;
                end
            end
            READ:    if (issued && data_out_ready) state_nxt = RESP;
            WRITE:   if (issued && !busy)          state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            issued  <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Low on the first cycle of READ/WRITE, high from the second onward.
            issued <= (state == READ) || (state == WRITE);
            if ((state == IDLE) && req_valid) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
                if (req_misaligned) begin
                    error_q <= 1'b1;
                    rdata_q <= 32'd0;
                end
            end
            if ((state == READ) && (state_nxt == RESP)) begin
                error_q <= 1'b0;
                rdata_q <= rdata_ext;
            end
            if ((state == WRITE) && (state_nxt == RESP)) begin
                error_q <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    assign req_ready    = (state == IDLE);
    assign rsp_valid    = (state == RESP);
    assign rsp_error    = error_q;
    assign rsp_rdata    = rdata_q;
    assign enable       = (state == READ) || (state == WRITE);
    assign address      = {addr_q[AW-1:2], 2'b00};
    assign data_in      = wdata_sized << {addr_q[1:0], 3'b000};
    assign write_enable = (state == WRITE) ? lane_mask : 4'b0000;

endmodule
